// File: rtl/door_pkg.sv
// door_pkg: shared constants and types for the door input conditioner
package door_pkg;
  localparam int DEBOUNCE_1MS = 2000;
  typedef enum logic [1:0] {
    CH_KEY_UP,
    CH_KEY_DOWN,
    CH_SENSE_UP,
    CH_SENSE_DOWN
  } door_ch_e;
  typedef logic [3:0] door_in_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser plus counter debouncer with rising-edge pulse
module debounce_channel
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, expire;
  logic [CNT_W-1:0] cnt;
  assign expire = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk2m or negedge rst_n)
    if (!rst_n) {s1, s2, cnt, dout, rise} <= '0;
    else begin
      s1   <= din;
      s2   <= s1;
      cnt  <= (s2 == dout || expire) ? '0 : cnt + 1'b1;
      dout <= (s2 != dout && expire) ? s2 : dout;
      rise <= s2 & ~dout & expire;
    end
endmodule

// File: rtl/door_input_conditioner.sv
// door_input_conditioner: debounces door keys and limit switches, flags implausible sensors
module door_input_conditioner
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sense_up_raw,
  input  logic sense_down_raw,
  output logic key_up,
  output logic key_down,
  output logic sense_up,
  output logic sense_down,
  output logic key_up_pulse,
  output logic key_down_pulse,
  output logic sense_err
);
  door_in_t raw, clean, rise;
  logic err_q, unused_rise;
  assign raw[CH_KEY_UP]     = key_up_raw;
  assign raw[CH_KEY_DOWN]   = key_down_raw;
  assign raw[CH_SENSE_UP]   = sense_up_raw;
  assign raw[CH_SENSE_DOWN] = sense_down_raw;
  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk2m(clk2m),
      .rst_n(rst_n),
      .din  (raw[i]),
      .dout (clean[i]),
      .rise (rise[i])
    );
  end
  assign key_up         = clean[CH_KEY_UP];
  assign key_down       = clean[CH_KEY_DOWN];
  assign sense_up       = clean[CH_SENSE_UP];
  assign sense_down     = clean[CH_SENSE_DOWN];
  assign key_up_pulse   = rise[CH_KEY_UP];
  assign key_down_pulse = rise[CH_KEY_DOWN];
  assign unused_rise    = rise[CH_SENSE_UP] ^ rise[CH_SENSE_DOWN];
  // error reported in the same cycle both sensors settle high, then held
  assign sense_err = err_q | (sense_up & sense_down);
  always_ff @(posedge clk2m or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= sense_err;
endmodule
